// File: rtl/stream_decimator.sv
// -----------------------------------------------------------------------------
// stream_decimator
//
// Block-averaging decimator for a signed sample stream. Every DECIM accepted
// input samples are summed and divided by DECIM with an arithmetic shift. The
// result is tagged with a 16-bit sequence number and pushed into a small
// first-word-fall-through output FIFO. A stalled consumer back-pressures the
// producer only on the final sample of a block, so no sample is ever lost.
//
// Build option:
//   STREAM_DECIMATOR_ROUND_EN  defined   -> result rounds half toward +inf
//                              undefined -> result is floor(sum / DECIM)
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   flush       1-cycle pulse, drops the partial block (FIFO and seq kept)
//   in_valid    input sample valid
//   in_ready    input sample accepted when in_valid && in_ready
//   in_data     signed input sample, DW bits
//   out_valid   FIFO head valid
//   out_ready   consumer pops the head when out_valid && out_ready
//   out_data    signed averaged sample at the FIFO head
//   out_seq     sequence number of the FIFO head
//   fifo_level  number of occupied FIFO entries
// -----------------------------------------------------------------------------
module stream_decimator #(
    parameter int DW         = 17,
    parameter int DECIM      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DW-1:0]               in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DW-1:0]               out_data,
    output logic [15:0]                 out_seq,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int LG    = $clog2(DECIM);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int ACC_W = DW + LG;
    localparam int LVL_W = AW + 1;

    localparam logic [LG-1:0]    PHASE_LAST = LG'(DECIM - 1);
    localparam logic [LG-1:0]    PHASE_ONE  = LG'(1'b1);
    localparam logic [AW-1:0]    PTR_ONE    = AW'(1'b1);
    localparam logic [LVL_W-1:0] LVL_ONE    = LVL_W'(1'b1);
    localparam logic [LVL_W-1:0] LVL_FULL   = LVL_W'(FIFO_DEPTH);
`ifdef STREAM_DECIMATOR_ROUND_EN
    // Half of one LSB of the shifted result, added before the shift.
    localparam logic [ACC_W:0]   RND_BIAS   = (ACC_W + 1)'(1'b1) << (LG - 1);
`endif

    // Sign-extend one input sample to accumulator width.
    function automatic logic signed [ACC_W-1:0] sext_sample(input logic [DW-1:0] s);
        return ACC_W'($signed(s));
    endfunction

    // State
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [LG-1:0]           phase_q, phase_d;
    logic [15:0]             seq_q, seq_d;
    logic [DW-1:0]           data_mem_q [FIFO_DEPTH];
    logic [DW-1:0]           data_mem_d [FIFO_DEPTH];
    logic [15:0]             seq_mem_q  [FIFO_DEPTH];
    logic [15:0]             seq_mem_d  [FIFO_DEPTH];
    logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]        level_q, level_d;
    logic                    valid_q, valid_d;

    // Combinational intermediates
    logic                    fifo_full_s;
    logic                    final_s;
    logic                    pop_s;
    logic                    in_ready_s;
    logic                    accept_s;
    logic                    push_s;
    logic signed [ACC_W-1:0] sum_s;
    logic [DW-1:0]           result_s;
`ifdef STREAM_DECIMATOR_ROUND_EN
    logic signed [ACC_W:0]   sum_rnd_s;
    logic                    unused_rnd_bits_s;
`endif

    // Handshake: only the final sample of a block needs FIFO room; a pop in the
    // same cycle frees the slot, so a full FIFO being drained still accepts.
    always_comb begin
        fifo_full_s = (level_q == LVL_FULL);
        final_s     = (phase_q == PHASE_LAST);
        pop_s       = valid_q && out_ready;
        if (flush) begin
            in_ready_s = 1'b0;
        end else begin
            in_ready_s = !final_s || !fifo_full_s || pop_s;
        end
        accept_s = in_valid && in_ready_s;
        push_s   = accept_s && final_s;
    end

    // Block sum and scaled result. Taking bits [LG +: DW] of the sum is the
    // low DW bits of an arithmetic right shift by LG.
    always_comb begin
        sum_s = acc_q + sext_sample(in_data);
`ifdef STREAM_DECIMATOR_ROUND_EN
        // One extra bit keeps the biased max-positive sum from wrapping.
        sum_rnd_s         = {sum_s[ACC_W-1], sum_s} + RND_BIAS;
        result_s          = sum_rnd_s[LG +: DW];
        unused_rnd_bits_s = ^{sum_rnd_s[ACC_W], sum_rnd_s[LG-1:0]};
`else
        result_s          = sum_s[LG +: DW];
`endif
    end

    // Accumulator, phase and sequence counter next state.
    always_comb begin
        acc_d   = acc_q;
        phase_d = phase_q;
        seq_d   = seq_q;
        if (flush) begin
            acc_d   = {ACC_W{1'b0}};
            phase_d = {LG{1'b0}};
        end else if (accept_s) begin
            if (final_s) begin
                acc_d   = {ACC_W{1'b0}};
                phase_d = {LG{1'b0}};
                seq_d   = seq_q + 16'd1;
            end else begin
                acc_d   = sum_s;
                phase_d = phase_q + PHASE_ONE;
            end
        end else begin
            acc_d   = acc_q;
            phase_d = phase_q;
        end
    end

    // Output FIFO next state; pointers wrap naturally since depth is 2**AW.
    always_comb begin
        data_mem_d = data_mem_q;
        seq_mem_d  = seq_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (push_s) begin
            data_mem_d[wr_ptr_q] = result_s;
            seq_mem_d[wr_ptr_q]  = seq_q;
            wr_ptr_d             = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
        valid_d = (level_d != {LVL_W{1'b0}});
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= {ACC_W{1'b0}};
            phase_q  <= {LG{1'b0}};
            seq_q    <= 16'd0;
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            level_q  <= {LVL_W{1'b0}};
            valid_q  <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                data_mem_q[i] <= {DW{1'b0}};
                seq_mem_q[i]  <= 16'd0;
            end
        end else begin
            acc_q      <= acc_d;
            phase_q    <= phase_d;
            seq_q      <= seq_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            valid_q    <= valid_d;
            data_mem_q <= data_mem_d;
            seq_mem_q  <= seq_mem_d;
        end
    end

    assign in_ready   = in_ready_s;
    assign out_valid  = valid_q;
    assign out_data   = data_mem_q[rd_ptr_q];
    assign out_seq    = seq_mem_q[rd_ptr_q];
    assign fifo_level = level_q;

endmodule
